// File: rtl/perf_pkg.sv
// Shared state encodings and sizing helper for the performance event monitor.
package perf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} run_state_t;
  typedef enum logic {SIDLE, SEND} snap_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag; wraps or saturates on overflow.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc_i) begin
      if (&cnt_o) begin
        ovf_o <= 1'b1;
        cnt_o <= SATURATE ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Cycle counter plus NUM_EVENTS event counters, with a cycle limit and a
// snapshot that is streamed out one counter per valid/ready handshake.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int unsigned     NUM_EVENTS  = 4,
  parameter int unsigned     CNT_W       = 32,
  parameter longint unsigned CYCLE_LIMIT = 64,
  parameter bit              SATURATE    = 1'b0,
  localparam int unsigned    N           = NUM_EVENTS + 1,
  localparam int unsigned    IDX_W       = idx_w(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  snap_req_i,
  output logic                  snap_valid_o,
  input  logic                  snap_ready_i,
  output logic [IDX_W-1:0]      snap_idx_o,
  output logic [CNT_W-1:0]      snap_data_o,
  output logic                  snap_last_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic [N-1:0]          ovf_o
);

  if (NUM_EVENTS < 1 || NUM_EVENTS > 15) begin : g_bad_num_events
    $error("perf_event_monitor: NUM_EVENTS must be 1..15");
  end
  if (CNT_W < 8 || CNT_W > 64) begin : g_bad_cnt_w
    $error("perf_event_monitor: CNT_W must be 8..64");
  end
  if (CNT_W < 64 && CYCLE_LIMIT >= (64'd1 << CNT_W)) begin : g_bad_limit
    $error("perf_event_monitor: CYCLE_LIMIT does not fit in CNT_W bits");
  end

  localparam bit               HAS_LIMIT = (CYCLE_LIMIT != 0);
  // Halt is decided one edge early so the limiting edge still counts its events.
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(CYCLE_LIMIT - 64'd1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  run_state_t       run_q, run_d;
  snap_state_t      snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             capture;
  logic [N-1:0]     inc;
  logic [CNT_W-1:0] cnt    [N];
  logic [CNT_W-1:0] shadow [N];

  assign running_o = (run_q == RUN);
  assign done_o    = (run_q == HALT);
  assign inc       = running_o ? {event_i, 1'b1} : '0;

  for (genvar i = 0; i < N; i++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[i]),
      .clr_i (clear_i),
      .cnt_o (cnt[i]),
      .ovf_o (ovf_o[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) run_q <= IDLE;
    else       run_q <= run_d;
  end

  always_comb begin
    run_d = run_q;
    if (clear_i) begin
      run_d = IDLE;
    end else begin
      case (run_q)
        IDLE: if (start_i) run_d = RUN;
        RUN: begin
          if (HAS_LIMIT && cnt[0] == LIMIT_M1) run_d = HALT;
          else if (!start_i)                   run_d = IDLE;
        end
        HALT:    run_d = HALT;
        default: run_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q <= SIDLE;
      idx_q  <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (snap_q)
      SIDLE: begin
        if (snap_req_i) begin
          snap_d  = SEND;
          idx_d   = '0;
          capture = 1'b1;
        end
      end
      SEND: begin
        if (snap_ready_i) begin
          if (idx_q == LAST_IDX) begin
            snap_d = SIDLE;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: snap_d = SIDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N; i++) shadow[i] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < N; i++) shadow[i] <= cnt[i];
    end
  end

  assign snap_valid_o = (snap_q == SEND);
  assign snap_idx_o   = idx_q;
  assign snap_last_o  = snap_valid_o && (idx_q == LAST_IDX);
  assign snap_data_o  = snap_valid_o ? shadow[idx_q] : '0;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench: three monitor instances (32-bit limited, 8-bit wrap, 8-bit saturate) share stimulus.
module tb_perf_event_monitor;

  localparam int NI = 3;
  localparam int N  = 5;

  typedef struct packed {
    logic [2:0]           idx;
    logic                 last;
    logic [NI-1:0][63:0]  d;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, clear = 1'b0, req = 1'b0, ready = 1'b0;
  logic [3:0] ev = '0;

  logic        v    [NI];
  logic [2:0]  ix   [NI];
  logic        lst  [NI];
  logic        runo [NI];
  logic        dno  [NI];
  logic [4:0]  ovf  [NI];
  logic [31:0] d0;
  logic [7:0]  d1, d2;
  logic [63:0] dv   [NI];

  assign dv[0] = 64'(d0);
  assign dv[1] = 64'(d1);
  assign dv[2] = 64'(d2);

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(32), .CYCLE_LIMIT(64), .SATURATE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_req_i(req), .snap_valid_o(v[0]), .snap_ready_i(ready), .snap_idx_o(ix[0]),
    .snap_data_o(d0), .snap_last_o(lst[0]), .running_o(runo[0]), .done_o(dno[0]), .ovf_o(ovf[0]));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_req_i(req), .snap_valid_o(v[1]), .snap_ready_i(ready), .snap_idx_o(ix[1]),
    .snap_data_o(d1), .snap_last_o(lst[1]), .running_o(runo[1]), .done_o(dno[1]), .ovf_o(ovf[1]));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_req_i(req), .snap_valid_o(v[2]), .snap_ready_i(ready), .snap_idx_o(ix[2]),
    .snap_data_o(d2), .snap_last_o(lst[2]), .running_o(runo[2]), .done_o(dno[2]), .ovf_o(ovf[2]));

  // Reference model: per-instance counter values, flags and run mode (0 idle, 1 run, 2 halt).
  int unsigned     mw   [NI] = '{32, 8, 8};
  longint unsigned mlim [NI] = '{64, 0, 0};
  bit              msat [NI] = '{1'b0, 1'b0, 1'b1};
  longint unsigned mcnt [NI][N];
  bit [4:0]        movf [NI];
  int              mst  [NI];
  int              rem;
  word_t           exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint unsigned maxv(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < N; k++) mcnt[i][k] = 0;
      movf[i] = '0;
      mst[i]  = 0;
    end
    rem = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    word_t w;
    bit    inc;
    if (rem == 0) begin
      if (req) begin
        for (int k = 0; k < N; k++) begin
          w.idx  = 3'(k);
          w.last = (k == N - 1);
          for (int i = 0; i < NI; i++) w.d[i] = mcnt[i][k];
          exp_q.push_back(w);
        end
        rem = N;
      end
    end else if (ready) begin
      rem--;
    end
    for (int i = 0; i < NI; i++) begin
      if (clear) begin
        for (int k = 0; k < N; k++) mcnt[i][k] = 0;
        movf[i] = '0;
        mst[i]  = 0;
      end else begin
        if (mst[i] == 1) begin
          for (int k = 0; k < N; k++) begin
            inc = (k == 0) ? 1'b1 : ev[k-1];
            if (inc) begin
              if (mcnt[i][k] == maxv(mw[i])) begin
                movf[i][k] = 1'b1;
                if (!msat[i]) mcnt[i][k] = 0;
              end else begin
                mcnt[i][k]++;
              end
            end
          end
        end
        case (mst[i])
          0: if (start) mst[i] = 1;
          1: begin
            if (mlim[i] != 0 && mcnt[i][0] == mlim[i]) mst[i] = 2;
            else if (!start)                           mst[i] = 0;
          end
          default: mst[i] = 2;
        endcase
      end
    end
  endtask

  task automatic check_status();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("running[%0d]", i), 64'(runo[i]), 64'(mst[i] == 1));
      chk($sformatf("done[%0d]", i),    64'(dno[i]),  64'(mst[i] == 2));
      chk($sformatf("ovf[%0d]", i),     64'(ovf[i]),  64'(movf[i]));
    end
  endtask

  task automatic step(input logic st, input logic cl, input logic [3:0] e,
                      input logic rq, input logic rd);
    start = st; clear = cl; ev = e; req = rq; ready = rd;
    @(posedge clk);
    model_edge();
    #1;
    check_status();
  endtask

  task automatic snap_and_drain(input bit toggle_ready, input bit rand_ev);
    step(1'b1, 1'b0, rand_ev ? 4'($urandom) : 4'h0, 1'b1, 1'b1);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++)
      step(start, 1'b0, rand_ev ? 4'($urandom) : 4'h0, 1'b0, toggle_ready ? 1'(t % 2 == 0) : 1'b1);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares every presented word; a word leaves the queue on its handshake.
  always @(negedge clk) begin
    word_t w;
    if (!rst && (v[0] || v[1] || v[2])) begin
      if (exp_q.size() == 0) begin
        chk("stream_unexpected_valid", 64'd1, 64'd0);
      end else begin
        w = exp_q[0];
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("snap_valid[%0d]", i), 64'(v[i]),   64'd1);
          chk($sformatf("snap_idx[%0d]", i),   64'(ix[i]),  64'(w.idx));
          chk($sformatf("snap_last[%0d]", i),  64'(lst[i]), 64'(w.last));
          chk($sformatf("snap_data[%0d]", i),  dv[i],       w.d[i]);
        end
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_valid[%0d]", i), 64'(v[i]),  64'd0);
      chk($sformatf("reset_idx[%0d]", i),   64'(ix[i]), 64'd0);
      chk($sformatf("reset_last[%0d]", i),  64'(lst[i]), 64'd0);
      chk($sformatf("reset_data[%0d]", i),  dv[i],      64'd0);
    end
    check_status();
    rst = 1'b0;

    // Plain cycle counting.
    repeat (10) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    snap_and_drain(1'b0, 1'b0);

    // Event 0 every 4th cycle until the 64-cycle limit halts instance 0.
    for (int c = 0; c < 80; c++) step(1'b1, 1'b0, (c % 4 == 3) ? 4'h1 : 4'h0, 1'b0, 1'b1);
    snap_and_drain(1'b0, 1'b0);

    // Mid-run snapshot with ready toggling and concurrent random events.
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 4'($urandom), 1'b0, 1'b1);
    snap_and_drain(1'b1, 1'b1);

    // Long all-ones event run: 8-bit instances wrap / saturate.
    step(1'b1, 1'b1, 4'hF, 1'b0, 1'b1);
    repeat (300) step(1'b1, 1'b0, 4'hF, 1'b0, 1'b1);
    snap_and_drain(1'b0, 1'b0);

    // Clear colliding with events, then a second request during SEND.
    repeat (5) step(1'b1, 1'b0, 4'hF, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'hF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("second_req_ignored", 64'(exp_q.size()), 64'd0);
    repeat (3) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++)
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 59) == 0), 4'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a stream, after the limit has been hit.
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
    repeat (70) step(1'b1, 1'b0, 4'($urandom), 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_mid_valid[%0d]", i), 64'(v[i]),   64'd0);
      chk($sformatf("rst_mid_done[%0d]", i),  64'(dno[i]), 64'd0);
      chk($sformatf("rst_mid_run[%0d]", i),   64'(runo[i]), 64'd0);
      chk($sformatf("rst_mid_ovf[%0d]", i),   64'(ovf[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("post_reset_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
